// File: rtl/inst_fetch.sv
// Instruction fetch front end: sequential PC with branch redirect, one-cycle
// memory read latency absorbed by a 2-entry {inst,pc} output buffer.
module inst_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] IOut,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int DEPTH = 2;

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              inflight_v_reg, inflight_v_next;
  logic [ADDR_W-1:0] inflight_pc_reg, inflight_pc_next;
  logic [1:0]        count_reg, count_next;
  logic              rd_ptr_reg, rd_ptr_next;
  logic              wr_ptr_reg, wr_ptr_next;

  logic [DATA_W-1:0] fifo_inst_reg [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_reg   [DEPTH];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign pop  = out_valid & out_ready;
  assign push = inflight_v_reg;

  // Slots already committed next cycle: buffered + returning read - leaving head.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_v_reg} - {2'b00, pop};
  assign issue     = ~redirect & (occupancy < 3'd2);

  always_comb begin
    pc_next          = pc_reg;
    inflight_v_next  = 1'b0;
    inflight_pc_next = inflight_pc_reg;
    count_next       = count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;

    if (redirect) begin
      pc_next     = redirect_addr;
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
    end else begin
      if (issue) begin
        pc_next          = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
        inflight_v_next  = 1'b1;
        inflight_pc_next = pc_reg;
      end
      if (push) begin
        wr_ptr_next = ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_next = ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      inflight_v_reg  <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= 2'd0;
      rd_ptr_reg      <= 1'b0;
      wr_ptr_reg      <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      inflight_v_reg  <= inflight_v_next;
      inflight_pc_reg <= inflight_pc_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // Buffer slots; a write during redirect is dropped along with the flush.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          fifo_inst_reg[gi] <= '0;
          fifo_pc_reg[gi]   <= '0;
        end else if (!redirect && push && (wr_ptr_reg == 1'(gi))) begin
          fifo_inst_reg[gi] <= IOut;
          fifo_pc_reg[gi]   <= inflight_pc_reg;
        end
      end
    end
  endgenerate

  assign addr      = pc_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_inst  = fifo_inst_reg[rd_ptr_reg];
  assign out_pc    = fifo_pc_reg[rd_ptr_reg];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory model, scoreboard of expected fetch PCs, and
// per-scenario tasks for streaming, backpressure, redirect, reset and wrap.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [31:0] iout;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [7:0]  out_pc;

  logic [7:0]  addr_w;
  logic [31:0] iout_w;
  logic        out_valid_w;
  logic [31:0] out_inst_w;
  logic [7:0]  out_pc_w;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wexp_q[$];

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst(rst), .addr(addr), .IOut(iout),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
  );

  inst_fetch #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'd254)) dut_wrap (
    .clk(clk), .rst(rst), .addr(addr_w), .IOut(iout_w),
    .redirect(1'b0), .redirect_addr(8'd0),
    .out_valid(out_valid_w), .out_ready(1'b1),
    .out_inst(out_inst_w), .out_pc(out_pc_w)
  );

  function automatic logic [31:0] inst_word(input logic [7:0] a);
    if (a == 8'd75) return 32'd3000;
    return 32'h1000 + {24'd0, a};
  endfunction

  // Synchronous memory: data for the address sampled at this edge appears next cycle.
  always @(posedge clk) begin
    iout   <= inst_word(addr);
    iout_w <= inst_word(addr_w);
  end

  // Scoreboard: every accepted head entry must be the next expected PC.
  always @(negedge clk) begin
    if (!rst && !redirect && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%0d inst=%h, required no output", out_pc, out_inst);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_pc !== e || out_inst !== inst_word(e)) begin
          errors++;
          $display("FAIL sb_txn: got pc=%0d inst=%h, required pc=%0d inst=%h",
                   out_pc, out_inst, e, inst_word(e));
        end else begin
          $display("txn pc=%0d inst=%h", out_pc, out_inst);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [7:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 8'(i));
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || addr !== 8'd0 || out_inst !== 32'd0 || out_pc !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b addr=%0d inst=%h pc=%0d, required 0 0 0 0",
               out_valid, addr, out_inst, out_pc);
    end
    checks++;
    if (addr_w !== 8'd254 || out_valid_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_pc_param: got addr=%0d v=%b, required 254 0", addr_w, out_valid_w);
    end
  endtask

  task automatic test_stream();
    load_exp(8'd0, 64);
    rst = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency1: got v=%b, required 0", out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'd0 || out_inst !== 32'h1000) begin
      errors++;
      $display("FAIL stream_first: got v=%b pc=%0d inst=%h, required 1 0 00001000",
               out_valid, out_pc, out_inst);
    end
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'(i)) begin
        errors++;
        $display("FAIL stream_nogap: got v=%b pc=%0d, required 1 %0d", out_valid, out_pc, i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  hold_pc;
    logic [31:0] hold_inst;
    logic [7:0]  hold_addr;
    out_ready = 1'b0;
    hold_pc   = out_pc;
    hold_inst = out_inst;
    hold_addr = addr;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== hold_pc || out_inst !== hold_inst || addr !== hold_addr) begin
        errors++;
        $display("FAIL bp_hold: got v=%b pc=%0d inst=%h addr=%0d, required 1 %0d %h %0d",
                 out_valid, out_pc, out_inst, addr, hold_pc, hold_inst, hold_addr);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_resume: got v=%b, required 1", out_valid);
      end
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    repeat (3) cyc();
    out_ready     = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 8'd75;
    load_exp(8'd75, 32);
    cyc();
    redirect = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || addr !== 8'd75) begin
      errors++;
      $display("FAIL redir_flush: got v=%b addr=%0d, required 0 75", out_valid, addr);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_bubble: got v=%b, required 0", out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'd75 || out_inst !== 32'd3000) begin
      errors++;
      $display("FAIL redir_target: got v=%b pc=%0d inst=%0d, required 1 75 3000",
               out_valid, out_pc, out_inst);
    end
    cyc();
    checks++;
    if (out_pc !== 8'd76 || out_inst !== 32'h104C) begin
      errors++;
      $display("FAIL redir_next: got pc=%0d inst=%h, required 76 0000104c", out_pc, out_inst);
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    repeat (2) cyc();
    rst       = 1'b1;
    out_ready = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || addr !== 8'd0 || out_inst !== 32'd0 || out_pc !== 8'd0) begin
      errors++;
      $display("FAIL midrst_state: got v=%b addr=%0d inst=%h pc=%0d, required 0 0 0 0",
               out_valid, addr, out_inst, out_pc);
    end
    rst = 1'b0;
    load_exp(8'd0, 32);
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_latency: got v=%b, required 0", out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'd0 || out_inst !== 32'h1000) begin
      errors++;
      $display("FAIL midrst_restart: got v=%b pc=%0d inst=%h, required 1 0 00001000",
               out_valid, out_pc, out_inst);
    end
    repeat (3) cyc();
  endtask

  task automatic test_rst_redirect();
    rst           = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 8'd75;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || addr !== 8'd0) begin
      errors++;
      $display("FAIL rst_over_redir: got v=%b addr=%0d, required 0 0", out_valid, addr);
    end
    rst           = 1'b0;
    redirect_addr = 8'd40;
    load_exp(8'd40, 32);
    cyc();
    redirect = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || addr !== 8'd40) begin
      errors++;
      $display("FAIL post_rst_redir: got v=%b addr=%0d, required 0 40", out_valid, addr);
    end
    cyc();
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'd40) begin
      errors++;
      $display("FAIL post_rst_redir_first: got v=%b pc=%0d, required 1 40", out_valid, out_pc);
    end
    repeat (3) cyc();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    load_exp(8'd0, 32);
    wexp_q.delete();
    wexp_q.push_back(8'd254);
    wexp_q.push_back(8'd255);
    wexp_q.push_back(8'd0);
    wexp_q.push_back(8'd1);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = wexp_q.pop_front();
      checks++;
      if (out_valid_w !== 1'b1 || out_pc_w !== e || out_inst_w !== inst_word(e)) begin
        errors++;
        $display("FAIL wrap_seq: got v=%b pc=%0d inst=%h, required 1 %0d %h",
                 out_valid_w, out_pc_w, out_inst_w, e, inst_word(e));
      end else begin
        $display("txn wrap pc=%0d inst=%h", out_pc_w, out_inst_w);
      end
      cyc();
    end
  endtask

  initial begin
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_addr = 8'd0;
    out_ready     = 1'b1;
    repeat (2) cyc();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_reset_midstream();
    test_rst_redirect();
    test_wrap();
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
